// File: rtl/usb_reg_master_pkg.sv
// rtl/usb_reg_master_pkg.sv - state encoding, timing minimums and timeout limit for usb_reg_master
package usb_reg_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_t;

  // Shortest phases the slave's 2-flop synchronisers and bytecnt logic can follow
  localparam int MIN_ADDR_CYC   = 2;
  localparam int MIN_STROBE_CYC = 4;
  localparam int MIN_HOLD_CYC   = 3;

  // Width of the shared phase timer; bounds the largest phase length
  localparam int TIMER_W = 8;

  // Write-SETUP cycles without data before the burst is abandoned
  localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;

endpackage

// File: rtl/usb_reg_master_timer.sv
// rtl/usb_reg_master_timer.sv - loadable down-counter timing the ADDR/STROBE/HOLD phases
import usb_reg_master_pkg::*;

module usb_reg_master_timer #(
  parameter int W = TIMER_W
) (
  input  logic         clk_usb,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins; otherwise count down and park at zero
  always_ff @(posedge clk_usb) begin
    if (reset)              count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/usb_reg_master.sv
// rtl/usb_reg_master.sv - command-driven initiator for the USB parallel register bus (option: USB_REG_MASTER_TIMEOUT_EN)
module usb_reg_master
  import usb_reg_master_pkg::*;
#(
  parameter int pBYTECNT_SIZE = 7,
  parameter int pADDR_CYC     = 2,
  parameter int pSTROBE_CYC   = 4,
  parameter int pHOLD_CYC     = 3
) (
  input  logic                     clk_usb,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [7:0]               cmd_addr,
  input  logic [pBYTECNT_SIZE-1:0] cmd_len,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [7:0]               cwusb_addr,
  output logic [7:0]               cwusb_din,
  output logic                     cwusb_din_oe,
  input  logic [7:0]               cwusb_dout,
  output logic                     cwusb_rdn,
  output logic                     cwusb_wrn,
  output logic                     cwusb_cen,
  output logic                     cwusb_alen
);

  if (pADDR_CYC < MIN_ADDR_CYC || pSTROBE_CYC < MIN_STROBE_CYC || pHOLD_CYC < MIN_HOLD_CYC ||
      pADDR_CYC > 2**TIMER_W || pSTROBE_CYC > 2**TIMER_W || pHOLD_CYC > 2**TIMER_W) begin : g_bad_timing
    $fatal(1, "usb_reg_master: phase length parameter out of range");
  end

  localparam logic [TIMER_W-1:0] ADDR_LD   = TIMER_W'(pADDR_CYC - 1);
  localparam logic [TIMER_W-1:0] STROBE_LD = TIMER_W'(pSTROBE_CYC - 1);
  localparam logic [TIMER_W-1:0] HOLD_LD   = TIMER_W'(pHOLD_CYC - 1);

  state_t                   state, state_next;
  logic                     is_write;
  logic [pBYTECNT_SIZE-1:0] byte_cnt;
  logic                     tmr_load, tmr_zero;
  logic [TIMER_W-1:0]       tmr_val;
  logic                     accept, consume, last_sample, timed_out;
  logic                     wr_burst, on_bus;

  usb_reg_master_timer #(.W(TIMER_W)) u_timer (
    .clk_usb  (clk_usb),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

`ifdef USB_REG_MASTER_TIMEOUT_EN
  logic [15:0] to_cnt;

  // Count write-SETUP cycles spent waiting for data; restart whenever the wait ends
  always_ff @(posedge clk_usb) begin
    if (reset || state != ST_SETUP || !is_write || wr_valid) to_cnt <= '0;
    else                                                      to_cnt <= to_cnt + 16'd1;
  end

  assign timed_out = (state == ST_SETUP) && is_write && !wr_valid &&
                     (to_cnt == TIMEOUT_LIMIT - 16'd1);
`else
  assign timed_out = 1'b0;
`endif

  // Next-state decode and phase-timer loads
  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    accept     = 1'b0;
    consume    = 1'b0;
    case (state)
      ST_IDLE: if (cmd_valid) begin
        accept     = 1'b1;
        state_next = ST_ADDR;
        tmr_load   = 1'b1;
        tmr_val    = ADDR_LD;
      end
      ST_ADDR: if (tmr_zero) state_next = ST_SETUP;
      ST_SETUP: begin
        if (!is_write || wr_valid) begin
          consume    = is_write;
          state_next = ST_STROBE;
          tmr_load   = 1'b1;
          tmr_val    = STROBE_LD;
        end else if (timed_out) begin
          state_next = ST_DONE;
        end
      end
      ST_STROBE: if (tmr_zero) begin
        state_next = ST_HOLD;
        tmr_load   = 1'b1;
        tmr_val    = HOLD_LD;
      end
      ST_HOLD: if (tmr_zero) state_next = (byte_cnt == '0) ? ST_DONE : ST_SETUP;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign last_sample = (state == ST_STROBE) && tmr_zero && !is_write;
  assign wr_burst    = accept ? cmd_write : is_write;
  assign on_bus      = (state_next == ST_SETUP) || (state_next == ST_STROBE) || (state_next == ST_HOLD);

  // State register, burst direction and remaining-byte counter
  always_ff @(posedge clk_usb) begin
    if (reset) begin
      state    <= ST_IDLE;
      is_write <= 1'b0;
      byte_cnt <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        is_write <= cmd_write;
        byte_cnt <= cmd_len;
      end else if (state == ST_HOLD && tmr_zero && byte_cnt != '0) begin
        byte_cnt <= byte_cnt - 1'b1;
      end
    end
  end

  // Registered outputs decoded from the next state so they line up with the state register
  always_ff @(posedge clk_usb) begin
    if (reset) begin
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      wr_ready     <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      err          <= 1'b0;
      cwusb_addr   <= '0;
      cwusb_din    <= '0;
      cwusb_din_oe <= 1'b0;
      cwusb_rdn    <= 1'b1;
      cwusb_wrn    <= 1'b1;
      cwusb_cen    <= 1'b1;
      cwusb_alen   <= 1'b0;
    end else begin
      cmd_ready    <= (state_next == ST_IDLE);
      busy         <= (state_next != ST_IDLE);
      done         <= (state_next == ST_DONE);
      cwusb_cen    <= !on_bus;
      cwusb_alen   <= on_bus;
      cwusb_din_oe <= wr_burst && (on_bus || state_next == ST_ADDR);
      cwusb_rdn    <= !(state_next == ST_STROBE && !wr_burst);
      cwusb_wrn    <= !(state_next == ST_STROBE && wr_burst);
      wr_ready     <= consume;
      rd_valid     <= last_sample;
      if (consume)     cwusb_din  <= wr_data;
      if (last_sample) rd_data    <= cwusb_dout;
      if (accept)      cwusb_addr <= cmd_addr;
      if (accept)         err <= 1'b0;
      else if (timed_out) err <= 1'b1;
    end
  end

endmodule
